// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side controller:
// Gray code conversion, write FSM state encoding and grant-index width.
package fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } wr_state_e;

    // Width of a producer index; never narrower than one bit.
    function automatic int gw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after
// base_i (wrapping), returning a one-hot grant and its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] base_i,
    output logic [N-1:0]  gnt_o,
    output logic [GW-1:0] idx_o,
    output logic          any_o
);

    int            j;
    logic [GW-1:0] jj;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(base_i) + k) % N;
            jj = GW'(j);
            if (!any_o && req_i[jj]) begin
                any_o     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Async FIFO write side: round-robin shares the write port among producers with
// packet locking, and owns the binary/Gray write pointer and the full flag.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int  ADDRSIZE = 4,
    parameter int  DSIZE    = 8,
    parameter int  NREQ     = 4,
    localparam int GW       = gw_of(NREQ),
    localparam int PW       = ADDRSIZE + 1
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic [PW-1:0]         wq2_rptr,
    output logic                  wen,
    output logic [ADDRSIZE-1:0]   waddr,
    output logic [DSIZE-1:0]      wdata,
    output logic [PW-1:0]         wptr,
    output logic                  wfull,
    output logic [GW-1:0]         grant_id,
    output wr_state_e             dbg_state
);

    // Handshake: a word from producer i moves when req_valid[i] & req_ready[i]
    // at a rising wclk edge; req_ready depends only on registered state and
    // req_valid, so producers must not gate req_valid on req_ready.

    logic [PW-1:0]       wbin_q, wbin_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic                wfull_q, wfull_d;
    logic [GW-1:0]       last_grant_q, grant_id_q, lock_id_q;
    wr_state_e           state_q;
    logic                wen_q;
    logic [ADDRSIZE-1:0] waddr_q;
    logic [DSIZE-1:0]    wdata_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [GW-1:0]       arb_idx;
    logic                arb_any;
    logic [NREQ-1:0]     lock_onehot;
    logic [NREQ-1:0]     ready_raw;
    logic [GW-1:0]       cand;
    logic                cand_valid;
    logic                accept;
    logic [DSIZE-1:0]    cand_data;
    logic [PW-1:0]       rptr_full_cmp;

    rr_arbiter #(
        .N  (NREQ),
        .GW (GW)
    ) u_arb (
        .req_i  (req_valid),
        .base_i (last_grant_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    // While locked only the packet owner is eligible, whoever else is valid.
    always_comb begin
        lock_onehot            = '0;
        lock_onehot[lock_id_q] = 1'b1;
        if (state_q == LOCKED) begin
            cand       = lock_id_q;
            cand_valid = req_valid[lock_id_q];
            ready_raw  = lock_onehot & req_valid;
        end else begin
            cand       = arb_idx;
            cand_valid = arb_any;
            ready_raw  = arb_gnt;
        end
        req_ready = wfull_q ? '0 : ready_raw;
        accept    = cand_valid & ~wfull_q;
        cand_data = req_data[int'(cand)*DSIZE +: DSIZE];
    end

    // Full when the next Gray pointer equals the read pointer with its top two
    // bits inverted: exactly one lap ahead.
    always_comb begin
        wbin_d        = wbin_q + PW'(accept);
        wptr_d        = PW'(bin2gray(32'(wbin_d)));
        rptr_full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        wfull_d       = (wptr_d == rptr_full_cmp);
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q       <= '0;
            wptr_q       <= '0;
            wfull_q      <= 1'b0;
            last_grant_q <= GW'(NREQ - 1);
            grant_id_q   <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            wfull_q <= wfull_d;
            wen_q   <= accept;
            if (accept) begin
                waddr_q      <= wbin_q[ADDRSIZE-1:0];
                wdata_q      <= cand_data;
                last_grant_q <= cand;
                grant_id_q   <= cand;
            end
        end
    end

    // Packet lock: a non-last beat claims the port; the last beat releases it.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!req_last[cand]) begin
                        state_q   <= LOCKED;
                        lock_id_q <= cand;
                    end
                end
                LOCKED: begin
                    if (req_last[cand]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign grant_id  = grant_id_q;
    assign dbg_state = state_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the async FIFO: shares the single FIFO write port among NREQ producers in the wclk domain with round-robin arbitration and packet locking. Owns the binary/Gray write pointer and full flag, consuming the read pointer already synchronized into the write domain, and drives write enable, address and data for the dual-port memory.

## Interface
- ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE
- DSIZE, 8, data word width
- NREQ, 4, number of producers (≥2); GW = clog2(NREQ)
- wclk  in  1  write-domain clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  producer i has a word
- req_last  in  NREQ  word from producer i ends its packet
- req_data  in  NREQ*DSIZE  producer i data in bits [i*DSIZE +: DSIZE]
- req_ready  out  NREQ  word from producer i accepted this cycle (one-hot or zero)
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already synchronized to wclk
- wen  out  1  memory write strobe
- waddr  out  ADDRSIZE  memory write address
- wdata  out  DSIZE  memory write data
- wptr  out  ADDRSIZE+1  Gray write pointer, to the write-to-read synchronizer
- wfull  out  1  FIFO full
- grant_id  out  GW  index of last accepted producer

## Operation
- State: wbin (ADDRSIZE+1 binary), wptr (Gray of wbin), wfull, last_grant (GW), FSM {IDLE, LOCKED}, lock_id (GW).
- IDLE: candidate = first i with req_valid[i], searching from (last_grant+1) mod NREQ upward with wrap.
- LOCKED: candidate = lock_id only; other producers stall regardless of valid.
- req_ready[candidate] = req_valid[candidate] & ~wfull; all other bits 0. Accept = valid & ready.
- On accept: wbin += 1 (wraps mod 2^(ADDRSIZE+1)); wptr = bin2gray(wbin+1); last_grant, grant_id = candidate.
- FSM: IDLE --accept & ~req_last--> LOCKED (lock_id = candidate); LOCKED --accept & req_last--> IDLE; otherwise hold. A single-word packet (last on first beat) stays IDLE.
- Full: wfull <= (graynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}), graynext = Gray of wbin plus accept. Evaluated every cycle so wfull clears when the synchronized read pointer advances.
- wfull high: no accept; FSM and lock held; pending packet resumes when wfull clears.
- Write port: wen <= accept; waddr <= wbin[ADDRSIZE-1:0] (pre-increment); wdata <= req_data of candidate. When not accepting, wen = 0 and waddr/wdata hold.
- Reset (any time, including mid-packet): all state and outputs 0, FSM = IDLE, last_grant = NREQ-1 (producer 0 has first priority); grant_id resets to 0.

## Timing
- req_ready is combinational from registered state and req_valid; no req_ready-to-req_valid path allowed upstream.
- Accept at edge N -> wen/waddr/wdata valid for cycle N+1 (one-cycle latency, one-cycle wen pulse per word).
- wptr and wfull update at the same edge N as the accept; full throughput one word/cycle.
- wfull assertion is exact (asserts on the edge of the 2^ADDRSIZE-th outstanding accept); deassertion is pessimistic by the 2-cycle synchronizer delay.
- Pointer wrap: wbin MSB toggles every 2^ADDRSIZE words; waddr wraps 15->0 at default size.

## Structure
- Package fifo_pkg: bin2gray/gray2bin functions, FSM state enum {IDLE, LOCKED}, GW computation helper.
- Sub-module rr_arbiter (req, base pointer -> one-hot grant and index), purely combinational; pointer/full/FSM/write-port registers in the top.

## Test plan
- Reset release, only req_valid[2]=1, last=1, data 0xA5 -> req_ready=4'b0100; next cycle wen=1, waddr=0, wdata=0xA5; wptr=5'b00001.
- All four valid, single-word packets continuously -> grants 0,1,2,3,0 in successive cycles; waddr 0,1,2,3,4.
- Producer 1 sends 3-word packet (last on 3rd) with producers 0,2 valid throughout -> three consecutive grants to 1, then 2, then 0.
- wq2_rptr held 0, 16 accepts -> wfull=1 after 16th accept edge, wptr=5'b11000, req_ready=0; set wq2_rptr=5'b00001 -> wfull=0 next edge, accept resumes at waddr 0.
- rst_n pulsed low in LOCKED mid-packet -> asynchronously wen=0, wfull=0, wptr=0; after release producer 0 wins over a pending producer 3.
